// File: rtl/q100_pkg.sv
// q100 shared types and constants.
// ITCM width macros fall back to 16/32 when the build does not set them.
`ifndef ITCM_ADDR_WIDTH
`define ITCM_ADDR_WIDTH 16
`endif
`ifndef ITCM_DATA_WIDTH
`define ITCM_DATA_WIDTH 32
`endif

package q100_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    EXT
  } arb_state_e;

  localparam int ARB_MAX_BURST_DEF = 4;

endpackage

// File: rtl/q100_itcm_arb.sv
// q100 ITCM port arbiter: boot loader / debug access vs. instruction fetch.
// Fetch owns the port in RUN; external bursts are bounded by MAX_BURST.
module q100_itcm_arb
  import q100_pkg::*;
#(
  parameter int AW        = `ITCM_ADDR_WIDTH,
  parameter int DW        = `ITCM_DATA_WIDTH,
  parameter int MAX_BURST = ARB_MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot_hold_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_data_o,
  output logic          if_pause_o,
  input  logic          ext_req_i,
  input  logic          ext_we_i,
  input  logic [AW-1:0] ext_addr_i,
  input  logic [DW-1:0] ext_wdata_i,
  output logic          ext_gnt_o,
  output logic          ext_rvalid_o,
  output logic [DW-1:0] ext_rdata_o,
  output logic [AW-1:0] itcm_addr_o,
  output logic          itcm_we_o,
  output logic [DW-1:0] itcm_wdata_o,
  input  logic [DW-1:0] itcm_data_i
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);

  arb_state_e    state;
  logic [CW-1:0] burst_cnt;
  logic          last_if;
  logic [DW-1:0] if_hold;
  logic          ext_own;
  logic          gnt;

  assign ext_own = (state == BOOT) | (state == EXT);

  // Gated by rst so an asserted reset drops the grant at once.
  assign gnt = rst & ext_req_i & ext_own;

  assign ext_gnt_o    = gnt;
  assign if_pause_o   = (state != RUN);
  assign itcm_addr_o  = gnt ? ext_addr_i : if_addr_i;
  assign itcm_we_o    = gnt & ext_we_i;
  assign itcm_wdata_o = ext_wdata_i;
  assign ext_rdata_o  = itcm_data_i;
  assign if_data_o    = last_if ? itcm_data_i : if_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= BOOT;
      burst_cnt    <= '0;
      last_if      <= 1'b0;
      if_hold      <= '0;
      ext_rvalid_o <= 1'b0;
    end else begin
      last_if      <= (state == RUN);
      ext_rvalid_o <= gnt & ~ext_we_i;
      if (last_if) begin
        if_hold <= itcm_data_i;
      end
      unique case (state)
        BOOT: begin
          burst_cnt <= '0;
          if (!boot_hold_i) begin
            state <= RUN;
          end
        end
        RUN: begin
          burst_cnt <= '0;
          if (ext_req_i || boot_hold_i) begin
            state <= EXT;
          end
        end
        EXT: begin
          if (boot_hold_i) begin
            // Saturate so a long held load cannot wrap the count.
            if (gnt && burst_cnt != CNT_MAX) begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end else if (!ext_req_i || burst_cnt >= CNT_LAST) begin
            state <= RUN;
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          state     <= BOOT;
          burst_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q100_itcm_arb.sv
// Bench for q100_itcm_arb: ITCM model, read scoreboard, fetch model.
// Random external traffic is checked against a word-level memory model.
module tb_q100_itcm_arb;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MB = 4;

  typedef struct {
    bit             we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } op_t;

  logic          clk;
  logic          rst;
  logic          boot_hold_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_data_o;
  logic          if_pause_o;
  logic          ext_req_i;
  logic          ext_we_i;
  logic [AW-1:0] ext_addr_i;
  logic [DW-1:0] ext_wdata_i;
  logic          ext_gnt_o;
  logic          ext_rvalid_o;
  logic [DW-1:0] ext_rdata_o;
  logic [AW-1:0] itcm_addr_o;
  logic          itcm_we_o;
  logic [DW-1:0] itcm_wdata_o;
  logic [DW-1:0] itcm_data_i;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] sb [$];
  op_t           ops [$];

  int checks = 0;
  int errors = 0;

  q100_itcm_arb #(
    .AW(AW),
    .DW(DW),
    .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .boot_hold_i(boot_hold_i),
    .if_addr_i(if_addr_i),
    .if_data_o(if_data_o),
    .if_pause_o(if_pause_o),
    .ext_req_i(ext_req_i),
    .ext_we_i(ext_we_i),
    .ext_addr_i(ext_addr_i),
    .ext_wdata_i(ext_wdata_i),
    .ext_gnt_o(ext_gnt_o),
    .ext_rvalid_o(ext_rvalid_o),
    .ext_rdata_o(ext_rdata_o),
    .itcm_addr_o(itcm_addr_o),
    .itcm_we_o(itcm_we_o),
    .itcm_wdata_o(itcm_wdata_o),
    .itcm_data_i(itcm_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ITCM macro: synchronous read, one cycle latency.
  always @(posedge clk) begin
    if (itcm_we_o) mem[itcm_addr_o] <= itcm_wdata_o;
    itcm_data_i <= mem[itcm_addr_o];
  end

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Read scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
    end else if (ext_rvalid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got rvalid=1 expected none");
      end else begin
        chk("rdata", ext_rdata_o, sb.pop_front());
      end
    end
  end

  // Fetch sees the word at the address of its most recent served cycle.
  logic [DW-1:0] exp_if;
  logic [DW-1:0] prev_word;
  bit            prev_run;
  always @(negedge clk) begin
    if (!rst) begin
      exp_if   = '0;
      prev_run = 1'b0;
    end else begin
      if (prev_run) exp_if = prev_word;
      chk("if_data", if_data_o, exp_if);
      prev_run  = !if_pause_o;
      prev_word = ref_mem[if_addr_i];
    end
  end

  function automatic bit exp_burst(input int k);
    return (k % (MB + 1)) != 0;
  endfunction

  task automatic drive(input op_t o);
    ext_req_i   = 1'b1;
    ext_we_i    = o.we;
    ext_addr_i  = o.addr;
    ext_wdata_i = o.data;
  endtask

  task automatic run_ops(input bit chk_burst, input bit chk_hold,
                         input logic [DW-1:0] hold_val,
                         input bit rnd_fetch);
    int  cyc = 0;
    bit  g;
    bit  prev_g = 0;
    bit  prev_wr = 0;
    bit  e;
    op_t cur;
    @(posedge clk);
    #1;
    if (ops.size() != 0) begin
      cur = ops.pop_front();
      drive(cur);
      while (1) begin
        @(negedge clk);
        cyc++;
        if (prev_g && prev_wr) chk("wr_no_rvalid", 32'(ext_rvalid_o), 0);
        g = ext_gnt_o;
        if (chk_burst) begin
          e = exp_burst(cyc - 1);
          chk("burst_gnt", 32'(g), 32'(e));
          chk("burst_pause", 32'(if_pause_o), 32'(e));
        end
        if (chk_hold && if_pause_o) chk("hold_data", if_data_o, hold_val);
        chk("gnt_in_run", 32'(g && !if_pause_o), 0);
        if (g) begin
          if (cur.we) ref_mem[cur.addr] = cur.data;
          else sb.push_back(ref_mem[cur.addr]);
        end
        prev_g  = g;
        prev_wr = cur.we;
        @(posedge clk);
        #1;
        if (rnd_fetch) if_addr_i = AW'($urandom);
        if (g) begin
          if (ops.size() == 0) begin
            ext_req_i = 1'b0;
            break;
          end
          cur = ops.pop_front();
          drive(cur);
        end
        if (cyc >= 200) begin
          checks++;
          errors++;
          $display("FAIL ops_timeout: got %0d ops left expected 0",
                   ops.size());
          ops.delete();
          ext_req_i = 1'b0;
          break;
        end
      end
    end
  endtask

  function automatic op_t mk(input bit we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    op_t o;
    o.we   = we;
    o.addr = a;
    o.data = d;
    return o;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    rst         = 1'b0;
    boot_hold_i = 1'b1;
    if_addr_i   = '0;
    ext_req_i   = 1'b0;
    ext_we_i    = 1'b0;
    ext_addr_i  = '0;
    ext_wdata_i = '0;

    @(negedge clk);
    chk("rst_pause", 32'(if_pause_o), 1);
    chk("rst_gnt", 32'(ext_gnt_o), 0);
    chk("rst_rvalid", 32'(ext_rvalid_o), 0);
    chk("rst_if_data", if_data_o, 0);
    chk("rst_we", 32'(itcm_we_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Boot load: 16 back-to-back writes.
    drive(mk(1'b1, 0, 0));
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("boot_gnt", 32'(ext_gnt_o), 1);
      chk("boot_pause", 32'(if_pause_o), 1);
      if (ext_gnt_o) ref_mem[AW'(4 * k)] = DW'(k);
      @(posedge clk);
      #1;
      drive(mk(1'b1, AW'(4 * (k + 1)), DW'(k + 1)));
    end
    ext_req_i   = 1'b0;
    boot_hold_i = 1'b0;
    if_addr_i   = 8'd8;
    @(negedge clk);
    chk("release_boot", 32'(if_pause_o), 1);
    @(negedge clk);
    chk("release_run", 32'(if_pause_o), 0);
    @(negedge clk);
    chk("boot_fetch", if_data_o, 2);

    // Continuous requests from RUN: bounded bursts with fetch slots.
    for (int i = 0; i < 12; i++) ops.push_back(mk(1'b0, AW'(4 * i), 0));
    run_ops(1'b1, 1'b0, 0, 1'b0);

    // Read return after a write.
    ops.push_back(mk(1'b1, 8'h10, 32'hDEADBEEF));
    ops.push_back(mk(1'b0, 8'h10, 0));
    run_ops(1'b0, 1'b0, 0, 1'b0);

    // Fetch word is held while the external side reads.
    ops.push_back(mk(1'b1, 8'h20, 32'h00500093));
    ops.push_back(mk(1'b1, 8'h40, 32'h12345678));
    run_ops(1'b0, 1'b0, 0, 1'b0);
    if_addr_i = 8'h20;
    repeat (3) @(negedge clk);
    chk("fetch_word", if_data_o, 32'h00500093);
    for (int i = 0; i < 3; i++) ops.push_back(mk(1'b0, 8'h40, 0));
    run_ops(1'b0, 1'b1, 32'h00500093, 1'b0);

    // boot_hold raised in RUN pauses fetch until released.
    repeat (2) @(posedge clk);
    #1;
    boot_hold_i = 1'b1;
    @(negedge clk);
    chk("bh_run", 32'(if_pause_o), 0);
    repeat (3) begin
      @(negedge clk);
      chk("bh_pause", 32'(if_pause_o), 1);
    end
    @(posedge clk);
    #1;
    boot_hold_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bh_release", 32'(if_pause_o), 0);

    // Asynchronous reset in the middle of a read burst.
    @(posedge clk);
    #1;
    boot_hold_i = 1'b1;
    drive(mk(1'b0, 8'h10, 0));
    repeat (3) begin
      @(negedge clk);
      if (ext_gnt_o) sb.push_back(ref_mem[8'h10]);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_gnt", 32'(ext_gnt_o), 0);
    chk("arst_rvalid", 32'(ext_rvalid_o), 0);
    chk("arst_pause", 32'(if_pause_o), 1);
    ext_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst         = 1'b1;
    boot_hold_i = 1'b0;
    @(negedge clk);
    chk("arst_boot", 32'(if_pause_o), 1);
    @(negedge clk);
    chk("arst_to_run", 32'(if_pause_o), 0);

    // Random traffic with random fetch addresses.
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
        if_addr_i = AW'($urandom);
      end
      repeat ($urandom_range(1, 5)) begin
        ops.push_back(mk(1'($urandom), AW'($urandom), DW'($urandom)));
      end
      run_ops(1'b0, 1'b0, 0, 1'b1);
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
